conv_decoder: RTL and testbench

Hard-decision Viterbi decoder for the receiver side of the UART link. It accepts one 32-bit convolutional codeword and recovers the 14-bit message. The codeword is the rate-1/2, K=3 code produced by the transmitter `encode` block (generators g0=111, g1=101, two zero tail bits). The block sits between the UART receive deframer, which assembles the 32 coded bits, and the message sink.

---
 rtl/conv_decoder.sv | 139 +++++++++++++
 tb/tb_conv_decoder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_decoder.sv
// Hard-decision Viterbi decoder for the K=3, rate-1/2 (g0=111, g1=101) code.
// Takes one 32-bit codeword (14 message bits + 2 zero tail bits). It runs 16
// add-compare-select steps and then 16 traceback steps. The result is then
// presented for one cycle on out_valid.
module conv_decoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] code_in,
  output logic        in_ready,
  output logic        out_valid,
  output logic [13:0] msg_out,
  output logic [5:0]  err_metric
);

  typedef enum logic [1:0] {ST_IDLE, ST_ACS, ST_TB, ST_DONE} state_t;

  state_t      state, state_nxt;
  logic [3:0]  step;          // trellis step during ACS, traceback count during TB
  logic [31:0] code_q;        // received word, shifted left two bits per ACS step
  logic [1:0]  rx;            // received {g0,g1} pair for the current step
  logic [5:0]  pm [4];        // path metrics indexed by encoder state {s1,s0}
  logic [5:0]  pm_nxt [4];
  logic [5:0]  cand0 [4];     // candidate via predecessor {s1,0}
  logic [5:0]  cand1 [4];     // candidate via predecessor {s1,1}
  logic [3:0]  dec_nxt;       // per-state survivor decision for this step
  logic [3:0]  surv [16];     // survivor decisions, one row per trellis step
  logic [1:0]  tb_state;      // encoder state being traced back
  logic [3:0]  tb_idx;
  logic        tb_dec;
  logic [12:0] bits;          // traceback bits collected so far, newest at the top
  logic        last_step;

  assign rx        = code_q[31:30];
  assign last_step = (step == 4'd15);
  assign tb_idx    = ~step;   // traceback walks from step 15 down to 0
  assign tb_dec    = surv[tb_idx][tb_state];

  // Saturating add; only unreachable start states ever hit the ceiling.
  function automatic logic [5:0] sat_add(input logic [5:0] a, input logic [1:0] b);
    logic [6:0] s;
    s = {1'b0, a} + {5'b0, b};
    return s[6] ? 6'd63 : s[5:0];
  endfunction

  // Hamming distance between the received pair and a branch's {g0,g1}.
  function automatic logic [1:0] bmet(input logic [1:0] r, input logic u,
                                      input logic s1, input logic s0);
    logic g0, g1;
    g0 = u ^ s1 ^ s0;
    g1 = u ^ s0;
    return {1'b0, r[1] ^ g0} + {1'b0, r[0] ^ g1};
  endfunction

  // State register
  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  // NOTE: state_nxt gets a default before the case so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (in_valid)  state_nxt = ST_ACS;
      ST_ACS:  if (last_step) state_nxt = ST_TB;
      ST_TB:   if (last_step) state_nxt = ST_DONE;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state
  always_comb begin
    in_ready  = (state == ST_IDLE);
    out_valid = (state == ST_DONE);
  end

  // Add-compare-select for each next state n = {u,s1}; ties keep predecessor s0=0
  always_comb begin
    for (int n = 0; n < 4; n++) begin
      cand0[n]   = sat_add(pm[{n[0], 1'b0}], bmet(rx, n[1], n[0], 1'b0));
      cand1[n]   = sat_add(pm[{n[0], 1'b1}], bmet(rx, n[1], n[0], 1'b1));
      dec_nxt[n] = (cand1[n] < cand0[n]);
      pm_nxt[n]  = dec_nxt[n] ? cand1[n] : cand0[n];
    end
  end

  // Datapath: word capture, metric update, traceback walk and result latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step       <= '0;
      code_q     <= '0;
      tb_state   <= '0;
      bits       <= '0;
      msg_out    <= '0;
      err_metric <= '0;
      for (int i = 0; i < 4; i++) pm[i] <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            code_q <= code_in;
            step   <= '0;
            pm[0]  <= 6'd0;
            pm[1]  <= 6'd63;
            pm[2]  <= 6'd63;
            pm[3]  <= 6'd63;
          end
        end
        ST_ACS: begin
          code_q <= code_q << 2;
          step   <= step + 4'd1;
          for (int i = 0; i < 4; i++) pm[i] <= pm_nxt[i];
          if (last_step) tb_state <= 2'b00;   // the tail forces the end state to 0
        end
        ST_TB: begin
          step     <= step + 4'd1;
          tb_state <= {tb_state[0], tb_dec};
          bits     <= {tb_state[1], bits[12:1]};
          if (last_step) begin
            // The final decoded bit belongs to step 0; tail bits have been shifted out.
            msg_out    <= {tb_state[1], bits};
            err_metric <= pm[0];
          end
        end
        default: ;
      endcase
    end
  end

  // Survivor memory written once per ACS step
  // NOTE: no reset here; every row is rewritten during ACS before traceback reads it.
  always_ff @(posedge clk) begin
    if (state == ST_ACS) surv[step] <= dec_nxt;
  end

endmodule

// File: tb/tb_conv_decoder.sv
// Bench for conv_decoder. A behavioural Viterbi model with full-path survivors
// predicts each result. An edge-count model predicts handshake timing. One
// compare process checks every cycle. Literal values pin the known vectors.
module tb_conv_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] code_in = '0;
  logic        in_ready, out_valid;
  logic [13:0] msg_out;
  logic [5:0]  err_metric;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Model state: edges remaining until IDLE, and expected held outputs
  int          m_left = 0;
  logic [13:0] exp_msg = '0, pend_msg = '0;
  logic [5:0]  exp_err = '0, pend_err = '0;

  always #5 clk = ~clk;

  conv_decoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .code_in    (code_in),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .msg_out    (msg_out),
    .err_metric (err_metric)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Encoder reference: state {s1,s0}, g0=u^s1^s0, g1=u^s0, two zero tail bits
  function automatic logic [31:0] encode(input logic [13:0] msg);
    logic [15:0] u;
    logic        s1, s0, b;
    logic [31:0] c;
    u = {msg, 2'b00};
    s1 = 1'b0; s0 = 1'b0; c = '0;
    for (int t = 0; t < 16; t++) begin
      b = u[15-t];
      c[31-2*t] = b ^ s1 ^ s0;
      c[30-2*t] = b ^ s0;
      s0 = s1;
      s1 = b;
    end
    return c;
  endfunction

  // Viterbi with whole survivor paths carried per state (no traceback)
  task automatic model_decode(input logic [31:0] code, output logic [13:0] msg,
                              output logic [5:0] err);
    int          pm[4], npm[4];
    logic [15:0] path[4], npath[4];
    int          r0, r1, u, s1, p, c, best, bp, g0, g1;
    pm[0] = 0; pm[1] = 63; pm[2] = 63; pm[3] = 63;
    for (int i = 0; i < 4; i++) path[i] = '0;
    for (int t = 0; t < 16; t++) begin
      r0 = int'(code[31-2*t]);
      r1 = int'(code[30-2*t]);
      for (int n = 0; n < 4; n++) begin
        u = n / 2; s1 = n % 2; best = 0; bp = 0;
        for (int s0 = 0; s0 < 2; s0++) begin
          p  = s1 * 2 + s0;
          g0 = u ^ s1 ^ s0;
          g1 = u ^ s0;
          c  = pm[p] + ((r0 != g0) ? 1 : 0) + ((r1 != g1) ? 1 : 0);
          if (c > 63) c = 63;
          if (s0 == 0 || c < best) begin best = c; bp = p; end
        end
        npm[n]   = best;
        npath[n] = {path[bp][14:0], 1'(u)};
      end
      pm = npm;
      path = npath;
    end
    msg = path[0][15:2];
    err = 6'(pm[0]);
  endtask

  // Timing/result model, advanced on every clock edge and on reset
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_left = 0; exp_msg = '0; exp_err = '0;
    end else if (m_left != 0) begin
      m_left--;
      if (m_left == 1) begin exp_msg = pend_msg; exp_err = pend_err; end
    end else if (in_valid) begin
      m_left = 33;
      model_decode(code_in, pend_msg, pend_err);
    end
  end

  // Per-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("in_ready",   32'(in_ready),   32'(m_left == 0));
      check("out_valid",  32'(out_valid),  32'(m_left == 1));
      check("msg_out",    32'(msg_out),    32'(exp_msg));
      check("err_metric", 32'(err_metric), 32'(exp_err));
    end
  end

  task automatic wait_accept();
    bit ok;
    ok = 1'b0;
    for (int b = 0; b < 200; b++) begin
      @(posedge clk); #1;
      if (m_left == 33) begin ok = 1'b1; break; end
    end
    check("accept_timeout", 32'(ok), 32'd1);
  endtask

  // Returns the number of negedges after the accept edge until out_valid
  task automatic wait_out(output int k);
    k = 0;
    while (!out_valid && k < 60) begin @(negedge clk); k++; end
  endtask

  task automatic send(input logic [31:0] code, input bit lit,
                      input logic [13:0] lmsg, input logic [5:0] lerr);
    int k;
    @(negedge clk); #1;
    in_valid = 1'b1;
    code_in  = code;
    wait_accept();
    @(negedge clk); #1;
    in_valid = 1'b0;
    code_in  = $urandom;     // must be ignored after the accepting edge
    wait_out(k);
    check("latency", 32'(k), 32'd32);
    if (lit) begin
      check("lit_msg", 32'(msg_out), 32'(lmsg));
      check("lit_err", 32'(err_metric), 32'(lerr));
    end
  endtask

  initial begin
    logic [13:0] mm;
    logic [5:0]  me;
    logic [31:0] cw;
    int          k, b0, b1;
    time         t1, t2;

    // Model pins against hand-derived values
    check("pin_encode", encode(14'h34E9), 32'hD4BD92FB);
    model_decode(32'hD4BD92FB, mm, me);
    check("pin_model_msg", 32'(mm), 32'h34E9);
    check("pin_model_err", 32'(me), 32'd0);
    model_decode(32'hDAAAAAA7, mm, me);
    check("pin_model_ones", 32'(mm), 32'h3FFF);

    #2 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready",  32'(in_ready),   32'd1);
    check("rst_out_valid", 32'(out_valid),  32'd0);
    check("rst_msg",       32'(msg_out),    32'd0);
    check("rst_err",       32'(err_metric), 32'd0);
    #1 rst_n = 1'b1;

    // Test-plan vectors
    send(32'hD4BD92FB, 1'b1, 14'h34E9, 6'd0);
    send(32'h54BD92FB, 1'b1, 14'h34E9, 6'd1);
    send(32'h54BD92F9, 1'b1, 14'h34E9, 6'd2);
    send(32'hDAAAAAA7, 1'b1, 14'h3FFF, 6'd0);
    send(32'h00000000, 1'b1, 14'h0000, 6'd0);

    // Back-to-back with in_valid held high
    @(negedge clk); #1;
    in_valid = 1'b1;
    code_in  = 32'hD4BD92FB;
    wait_accept();
    @(negedge clk); #1;
    code_in = 32'hDAAAAAA7;
    wait_out(k);
    t1 = $time;
    check("b2b_lat1", 32'(k), 32'd32);
    check("b2b_msg1", 32'(msg_out), 32'h34E9);
    wait_accept();
    @(negedge clk); #1;
    in_valid = 1'b0;
    wait_out(k);
    t2 = $time;
    check("b2b_lat2", 32'(k), 32'd32);
    check("b2b_spacing", 32'((t2 - t1) / 10), 32'd34);
    check("b2b_msg2", 32'(msg_out), 32'h3FFF);

    // Reset in the middle of ACS (step 7 happens on the 8th edge after accept)
    @(negedge clk); #1;
    in_valid = 1'b1;
    code_in  = 32'h54BD92F9;
    wait_accept();
    @(negedge clk); #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready",  32'(in_ready),   32'd1);
    check("mid_rst_out_valid", 32'(out_valid),  32'd0);
    check("mid_rst_msg",       32'(msg_out),    32'd0);
    check("mid_rst_err",       32'(err_metric), 32'd0);
    @(negedge clk); #1 rst_n = 1'b1;
    send(32'hD4BD92FB, 1'b1, 14'h34E9, 6'd0);

    // Random stimulus: correctable words (<=2 distinct flips) and arbitrary words
    for (int i = 0; i < 24; i++) begin
      if (i % 2 == 0) begin
        mm = 14'($urandom);
        cw = encode(mm);
        b0 = $urandom_range(0, 31);
        b1 = $urandom_range(0, 31);
        if (i % 4 == 0) cw[b0] = ~cw[b0];
        if (i % 4 == 0 && b1 != b0) cw[b1] = ~cw[b1];
        me = 6'($countones(cw ^ encode(mm)));
        send(cw, 1'b1, mm, me);
      end else begin
        send($urandom, 1'b0, 14'h0, 6'h0);
      end
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish, %0d miscompares so far", n_err);
    $fatal(1);
  end

endmodule
